control_carro: RTL and testbench
================================

CONTROL_CARRO -- requirements
Module: control_carro

Interface
REQ-001 The block SHALL have parameter TICK_DIV, default 250000, giving clock cycles per advance step (minimum 2).
REQ-002 The block SHALL have parameter X_LIMIT, default 10'd600, giving the car X position at or above which the car is recycled.
REQ-003 The block SHALL have parameter HOLDOFF, default 2, giving the cycles after oSalto during which iCarroX is ignored.
REQ-004 The block SHALL have iClk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have iReset_n, input, 1 bit: the asynchronous, active-low reset.
REQ-006 The block SHALL have iStart, input, 1 bit: level that starts or restarts a game.
REQ-007 The block SHALL have iPausa, input, 1 bit: level that freezes advance timing.
REQ-008 The block SHALL have iColision, input, 1 bit: level that ends the game.
REQ-009 The block SHALL have iCarroX, input, 10 bits: the car X position fed back from the car position register.
REQ-010 The block SHALL have oPosicionX, output, 9 bits: spawn X lane seed for the car register.
REQ-011 The block SHALL have oPosicionY, output, 9 bits: spawn Y for the car register.
REQ-012 The block SHALL have oEnable, output, 1 bit: one-cycle load pulse for the car register.
REQ-013 The block SHALL have oSuma, output, 1 bit: one-cycle advance pulse, meaning X+1 in the car register.
REQ-014 The block SHALL have oSalto, output, 1 bit: one-cycle recycle pulse for the car register.
REQ-015 The block SHALL have oEstado, output, 2 bits: current FSM state.
REQ-016 The block SHALL have oPuntos, output, 8 bits: score.

Function
REQ-017 The FSM SHALL have states IDLE=0, SPAWN=1, RUN=2, OVER=3, and oEstado SHALL equal the registered state.
REQ-018 In IDLE, iStart=1 SHALL move the FSM to SPAWN on the next edge; in IDLE all pulse outputs SHALL be 0.
REQ-019 In SPAWN, the block SHALL assert oEnable for exactly one cycle with oPosicionX/oPosicionY valid in that same cycle, then move to RUN.
REQ-020 The spawn lane SHALL be oPosicionX=9'd100 when lfsr[0]=0 and 9'd300 otherwise; oPosicionY SHALL be {1'b0, lfsr[8:1]}; both outputs SHALL be registered and held until the next spawn.
REQ-021 The LFSR SHALL be 9 bits with polynomial x^9+x^5+1, shifting every clock in every state, with nonzero seed 9'h1A5.
REQ-022 In RUN, the tick counter SHALL count 0..TICK_DIV-1 and wrap; in the wrap cycle oSuma SHALL pulse for one cycle.
REQ-023 While iPausa=1, the tick counter SHALL hold and oSuma/oSalto SHALL be 0; on release, counting SHALL resume from the held value.
REQ-024 In RUN, with holdoff expired and iCarroX >= X_LIMIT, oSalto SHALL pulse for one cycle, the holdoff counter SHALL load HOLDOFF, and oPuntos SHALL increment.
REQ-025 oPuntos SHALL saturate at 8'd255.
REQ-026 Priority in RUN SHALL be iColision > oSalto > oSuma; when oSalto fires, oSuma SHALL be suppressed that cycle and the tick counter SHALL reset to 0.
REQ-027 iColision=1 in RUN SHALL move the FSM to OVER on the next edge with no pulse issued that cycle.
REQ-028 iColision SHALL be ignored outside RUN.
REQ-029 OVER SHALL hold oPuntos; iStart=1 in OVER SHALL clear oPuntos and the tick counter and move to SPAWN.
REQ-030 At most one of oEnable, oSuma, oSalto SHALL be 1 in any cycle.

Reset
REQ-031 iReset_n=0 SHALL asynchronously force state IDLE, lfsr=9'h1A5, tick and holdoff counters to 0, oPuntos=0, oPosicionX=0, oPosicionY=0, and all pulses to 0.
REQ-032 Reset SHALL be released synchronously on the iClk edge following iReset_n high.
REQ-033 Reset asserted mid-RUN SHALL truncate any pulse in progress.

Configuration
REQ-034 With CONTROL_CARRO_PUNTOS_EN defined, the score counter SHALL be built per REQ-024/025/029.
REQ-035 Without CONTROL_CARRO_PUNTOS_EN, oPuntos SHALL be tied to 8'd0, no score register SHALL exist, and all other behaviour SHALL be unchanged.

Structure
REQ-036 A shared package SHALL hold the state encoding, the lane constants 100/300, and the LFSR seed and taps.
REQ-037 The LFSR SHALL be a sub-module, lfsr9, with ports clock, reset and 9-bit value.
REQ-038 The FSM, counters and pulse logic SHALL remain in control_carro.

Verification (TICK_DIV=4, X_LIMIT=10, HOLDOFF=2)
REQ-039 Reset then iStart for 1 cycle -> oEnable pulses once 2 cycles later, with oPosicionX=300 for the first seed, then oEstado=2.
REQ-040 RUN with iCarroX=0 for 16 cycles -> exactly 4 oSuma pulses spaced 4 cycles apart.
REQ-041 iCarroX=10 held for 5 cycles -> one oSalto, no oSuma that cycle, oPuntos=1, second oSalto only after holdoff if still 10.
REQ-042 iPausa high for 10 cycles mid-count -> no pulses; first oSuma after release arrives after the remaining count.
REQ-043 iColision and iCarroX=10 in the same cycle -> no oSalto, oEstado=3, oPuntos unchanged; then iStart -> oPuntos=0 and oEnable pulses.
REQ-044 Force score to 255 and trigger oSalto -> oPuntos stays 255; iReset_n low mid-RUN -> all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/control_carro_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// control_carro_pkg: shared state encoding, spawn lane constants and LFSR seed/taps.
// Rev 1.0
package control_carro_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SPAWN = 2'd1,
    S_RUN   = 2'd2,
    S_OVER  = 2'd3
  } state_e;

  localparam logic [8:0] c_lane_a    = 9'd100;
  localparam logic [8:0] c_lane_b    = 9'd300;
  localparam logic [8:0] c_lfsr_seed = 9'h1A5;
  // x^9 + x^5 + 1 : feedback from bits 8 and 4
  localparam logic [8:0] c_lfsr_taps = 9'h110;

  function automatic logic [8:0] spawn_lane(input logic sel);
    return sel ? c_lane_b : c_lane_a;
  endfunction

endpackage
`default_nettype wire

// File: rtl/control_carro_lfsr9.sv
`timescale 1ns/1ps
`default_nettype none
// lfsr9: free-running 9-bit Fibonacci LFSR, shifts every clock, async active-low reset to the seed.
// Rev 1.0
module lfsr9
  import control_carro_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  output logic [8:0] value_o
);

  logic [8:0] lfsr_q;
  logic [8:0] lfsr_d;

  always_comb begin
    lfsr_d = {lfsr_q[7:0], ^(lfsr_q & c_lfsr_taps)};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) lfsr_q <= c_lfsr_seed;
    else         lfsr_q <= lfsr_d;
  end

  assign value_o = lfsr_q;

endmodule
`default_nettype wire

// File: rtl/control_carro.sv
`timescale 1ns/1ps
`default_nettype none
// control_carro: car spawn/advance/recycle sequencer with score. Score counter built only
// when CONTROL_CARRO_PUNTOS_EN is defined. Rev 1.0
module control_carro
  import control_carro_pkg::*;
#(
  parameter int         TICK_DIV = 250000,
  parameter logic [9:0] X_LIMIT  = 10'd600,
  parameter int         HOLDOFF  = 2
) (
  input  logic       iClk,
  input  logic       iReset_n,
  input  logic       iStart,
  input  logic       iPausa,
  input  logic       iColision,
  input  logic [9:0] iCarroX,
  output logic [8:0] oPosicionX,
  output logic [8:0] oPosicionY,
  output logic       oEnable,
  output logic       oSuma,
  output logic       oSalto,
  output logic [1:0] oEstado,
  output logic [7:0] oPuntos
);

  localparam int            TW       = $clog2(TICK_DIV);
  localparam int            HW       = $clog2(HOLDOFF + 2);
  localparam logic [TW-1:0] TICK_MAX = TW'(TICK_DIV - 1);
  localparam logic [HW-1:0] HOLD_LD  = HW'(HOLDOFF);

  state_e        state_q, state_d;
  logic [8:0]    lfsr;
  logic [TW-1:0] tick_q, tick_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [8:0]    posx_q, posx_d, posy_q, posy_d;
  logic          enable_q, enable_d, suma_q, suma_d, salto_q, salto_d;
  logic          w_run_active, w_salto, w_wrap, w_restart;

  lfsr9 u_lfsr (
    .clk_i   (iClk),
    .rst_ni  (iReset_n),
    .value_o (lfsr)
  );

  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) state_q <= S_IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (iStart) state_d = S_SPAWN;
      S_SPAWN: state_d = S_RUN;
      S_RUN:   if (iColision) state_d = S_OVER;
      S_OVER:  if (iStart) state_d = S_SPAWN;
      default: state_d = S_IDLE;
    endcase
  end

  // Collision outranks everything; pause freezes timing; recycle outranks advance.
  always_comb begin
    w_run_active = (state_q == S_RUN) && !iColision && !iPausa;
    w_salto      = w_run_active && (hold_q == '0) && (iCarroX >= X_LIMIT);
    w_wrap       = (tick_q == TICK_MAX);
    w_restart    = (state_q == S_OVER) && iStart;

    enable_d = (state_q == S_SPAWN);
    salto_d  = w_salto;
    suma_d   = w_run_active && !w_salto && w_wrap;

    tick_d = tick_q;
    hold_d = hold_q;
    if (w_restart) begin
      tick_d = '0;
      hold_d = '0;
    end else if (w_run_active) begin
      if (w_salto) begin
        tick_d = '0;
        hold_d = HOLD_LD;
      end else begin
        tick_d = w_wrap ? '0 : tick_q + 1'b1;
        if (hold_q != '0) hold_d = hold_q - 1'b1;
      end
    end

    posx_d = posx_q;
    posy_d = posy_q;
    if (state_q == S_SPAWN) begin
      posx_d = spawn_lane(lfsr[0]);
      posy_d = {1'b0, lfsr[8:1]};
    end
  end

  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      tick_q   <= '0;
      hold_q   <= '0;
      posx_q   <= '0;
      posy_q   <= '0;
      enable_q <= 1'b0;
      suma_q   <= 1'b0;
      salto_q  <= 1'b0;
    end else begin
      tick_q   <= tick_d;
      hold_q   <= hold_d;
      posx_q   <= posx_d;
      posy_q   <= posy_d;
      enable_q <= enable_d;
      suma_q   <= suma_d;
      salto_q  <= salto_d;
    end
  end

`ifdef CONTROL_CARRO_PUNTOS_EN
  logic [7:0] puntos_q, puntos_d;

  always_comb begin
    puntos_d = puntos_q;
    if (w_restart)                         puntos_d = '0;
    else if (w_salto && puntos_q != 8'hFF) puntos_d = puntos_q + 8'd1;
  end

  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) puntos_q <= '0;
    else           puntos_q <= puntos_d;
  end

  assign oPuntos = puntos_q;
`else
  assign oPuntos = 8'd0;
`endif

  assign oPosicionX = posx_q;
  assign oPosicionY = posy_q;
  assign oEnable    = enable_q;
  assign oSuma      = suma_q;
  assign oSalto     = salto_q;
  assign oEstado    = state_q;

endmodule
`default_nettype wire

// File: tb/tb_control_carro.sv
`timescale 1ns/1ps
`default_nettype none
// tb_control_carro: random + directed stimulus against a cycle-level game model.
// Rev 1.0
module tb_control_carro;

  localparam int TD = 4;
  localparam int XL = 10;
  localparam int HO = 2;

  logic       iClk = 1'b0;
  logic       iReset_n = 1'b0;
  logic       iStart = 1'b0, iPausa = 1'b0, iColision = 1'b0;
  logic [9:0] iCarroX = '0;
  logic [8:0] oPosicionX, oPosicionY;
  logic       oEnable, oSuma, oSalto;
  logic [1:0] oEstado;
  logic [7:0] oPuntos;

  int total = 0;
  int bad   = 0;

  control_carro #(.TICK_DIV(TD), .X_LIMIT(10'd10), .HOLDOFF(HO)) dut (
    .iClk(iClk), .iReset_n(iReset_n), .iStart(iStart), .iPausa(iPausa),
    .iColision(iColision), .iCarroX(iCarroX), .oPosicionX(oPosicionX),
    .oPosicionY(oPosicionY), .oEnable(oEnable), .oSuma(oSuma), .oSalto(oSalto),
    .oEstado(oEstado), .oPuntos(oPuntos)
  );

  always #5 iClk = ~iClk;

  typedef struct {
    int st, since, hold, score, lfsr, px, py, en, su, sa;
  } model_t;

  model_t m;

  function automatic model_t model_reset();
    model_t r;
    r.st = 0; r.since = 0; r.hold = 0; r.score = 0; r.lfsr = 'h1A5;
    r.px = 0; r.py = 0; r.en = 0; r.su = 0; r.sa = 0;
    return r;
  endfunction

  function automatic int exp_pts(int s);
`ifdef CONTROL_CARRO_PUNTOS_EN
    return s;
`else
    return 0 * s;
`endif
  endfunction

  // "since" = unpaused run cycles elapsed since the last advance/recycle
  function automatic model_t step(model_t c, bit start, bit pausa, bit col, int cx);
    model_t n = c;
    n.lfsr = ((c.lfsr << 1) | (((c.lfsr >> 8) ^ (c.lfsr >> 4)) & 1)) & 'h1FF;
    n.en = 0; n.su = 0; n.sa = 0;
    if (c.st == 0) begin
      if (start) n.st = 1;
    end else if (c.st == 1) begin
      n.en = 1;
      n.px = (c.lfsr % 2 == 1) ? 300 : 100;
      n.py = c.lfsr / 2;
      n.st = 2;
    end else if (c.st == 2) begin
      if (col) n.st = 3;
      else if (!pausa) begin
        if (c.hold == 0 && cx >= XL) begin
          n.sa = 1; n.hold = HO; n.since = 0;
          n.score = (c.score < 255) ? c.score + 1 : 255;
        end else begin
          n.hold = (c.hold > 0) ? c.hold - 1 : 0;
          n.since = (c.since + 1) % TD;
          n.su = (n.since == 0);
        end
      end
    end else begin
      if (start) begin
        n.st = 1; n.score = 0; n.since = 0; n.hold = 0;
      end
    end
    return n;
  endfunction

  always @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) m <= model_reset();
    else           m <= step(m, iStart, iPausa, iColision, int'(iCarroX));
  end

  task automatic check(string name, int act, int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge iClk) begin
    check("estado", int'(oEstado), m.st);
    check("enable", int'(oEnable), m.en);
    check("suma",   int'(oSuma),   m.su);
    check("salto",  int'(oSalto),  m.sa);
    check("posx",   int'(oPosicionX), m.px);
    check("posy",   int'(oPosicionY), m.py);
    check("puntos", int'(oPuntos), exp_pts(m.score));
    check("onehot", (int'(oEnable) + int'(oSuma) + int'(oSalto) <= 1) ? 1 : 0, 1);
  end

  task automatic cycle();
    @(negedge iClk);
    #1;
  endtask

  task automatic ensure_run();
    for (int i = 0; i < 10 && m.st != 2; i++) begin
      iStart = (m.st == 0 || m.st == 3);
      iColision = 1'b0;
      cycle();
    end
    iStart = 1'b0;
    check("reach_run", m.st, 2);
  endtask

  task automatic check_all_zero(string tag);
    check({tag, "_estado"}, int'(oEstado), 0);
    check({tag, "_enable"}, int'(oEnable), 0);
    check({tag, "_suma"},   int'(oSuma),   0);
    check({tag, "_salto"},  int'(oSalto),  0);
    check({tag, "_posx"},   int'(oPosicionX), 0);
    check({tag, "_posy"},   int'(oPosicionY), 0);
    check({tag, "_puntos"}, int'(oPuntos), 0);
  endtask

  initial begin
    int cnt;
    repeat (3) cycle();
    check_all_zero("reset");

    // first spawn right after reset release: lfsr has stepped once (0x14B)
    iReset_n = 1'b1; iStart = 1'b1;
    cycle();
    iStart = 1'b0;
    cycle();
    check("spawn_enable", int'(oEnable), 1);
    check("spawn_posx", int'(oPosicionX), 300);
    check("spawn_posy", int'(oPosicionY), 165);
    check("spawn_estado", int'(oEstado), 2);

    cnt = 0;
    for (int i = 0; i < 16; i++) begin
      cycle();
      cnt += int'(oSuma);
    end
    check("suma_count16", cnt, 4);

    cnt = 0;
    iCarroX = 10'd10;
    for (int i = 0; i < 5; i++) begin
      cycle();
      cnt += int'(oSalto);
    end
    iCarroX = 10'd0;
    check("salto_count5", cnt, 2);
    check("salto_puntos", int'(oPuntos), exp_pts(2));

    repeat (2) cycle();
    cnt = 0;
    iPausa = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cycle();
      cnt += int'(oSuma) + int'(oSalto);
    end
    iPausa = 1'b0;
    check("pause_pulses", cnt, 0);
    repeat (8) cycle();

    for (int i = 0; i < 2000; i++) begin
      iStart    = ($urandom_range(0, 15) == 0);
      iPausa    = ($urandom_range(0, 7) == 0);
      iColision = ($urandom_range(0, 39) == 0);
      iCarroX   = ($urandom_range(0, 5) == 0) ? 10'($urandom_range(10, 1023))
                                              : 10'($urandom_range(0, 9));
      cycle();
    end
    iStart = 1'b0; iPausa = 1'b0; iColision = 1'b0; iCarroX = '0;

    ensure_run();
    iColision = 1'b1; iCarroX = 10'd10;
    cycle();
    iColision = 1'b0; iCarroX = 10'd0;
    check("col_estado", int'(oEstado), 3);
    check("col_salto", int'(oSalto), 0);
    iStart = 1'b1;
    cycle();
    iStart = 1'b0;
    check("restart_puntos", int'(oPuntos), 0);
    cycle();
    check("restart_enable", int'(oEnable), 1);

    ensure_run();
    iCarroX = 10'd10;
    repeat (800) cycle();
    check("sat_puntos", int'(oPuntos), exp_pts(255));

    @(posedge iClk);
    #2 iReset_n = 1'b0;
    #1 check_all_zero("async_rst");
    iCarroX = '0;
    repeat (2) cycle();
    iReset_n = 1'b1;
    repeat (4) cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
